seg_scan_4digit: RTL and testbench

SEG_SCAN_4DIGIT -- requirements
Module: seg_scan_4digit

---
 rtl/seg_pkg.sv | 10 +
 rtl/hex_to_seg7.sv | 10 +
 rtl/seg_scan_4digit.sv | 63 ++++++
 tb/tb_seg_scan_4digit.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, font table and pending-buffer state type for the 4-digit scanner.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] FONT [0:15] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  typedef enum logic {EMPTY, FULL} buf_state_t;
endpackage

// File: rtl/hex_to_seg7.sv
// hex_to_seg7: active-low {g..a} decode of one hex nibble, with forced blank.
module hex_to_seg7
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  input  logic       blank,
  output logic [6:0] seg
);
  always_comb seg = blank ? SEG_BLANK : FONT[nib];
endmodule

// File: rtl/seg_scan_4digit.sv
// seg_scan_4digit: time-multiplexed 4-digit 7-segment driver with a one-word
// pending buffer that only reaches the display at frame boundaries.
module seg_scan_4digit
  import seg_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        blank_lz,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        frame_done
);
  localparam int CW = $clog2(SCAN_DIV);
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  buf_state_t state;
  logic [15:0] pend, disp;
  logic tick, boundary, hs, blank;
  logic [3:0] nib;
  logic [6:0] seg_next;
  assign tick = cnt == CW'(SCAN_DIV - 1);
  assign boundary = tick && idx == 2'(NUM_DIGITS - 1);
  assign in_ready = state == EMPTY;
  assign hs = in_valid && in_ready;
  assign nib = disp[{idx, 2'b00} +: 4];
  // a digit is a leading zero when it and every higher nibble are zero
  assign blank = blank_lz && idx != '0 && (disp >> {idx, 2'b00}) == '0;
  hex_to_seg7 u_font (
    .nib  (nib),
    .blank(blank),
    .seg  (seg_next)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      state <= EMPTY;
      pend <= '0;
      disp <= '0;
      an <= 4'hF;
      seg <= SEG_BLANK;
      frame_done <= 1'b0;
    end else begin
      cnt <= tick ? '0 : cnt + 1'b1;
      if (tick) idx <= idx + 1'b1;
      an <= ~(4'b0001 << idx);
      seg <= seg_next;
      frame_done <= boundary;
      // a handshake is only possible while EMPTY, so it never races the copy
      if (hs) begin
        pend <= in_data;
        state <= FULL;
      end else if (boundary && state == FULL) begin
        disp <= pend;
        state <= EMPTY;
      end
    end
endmodule

// File: tb/tb_seg_scan_4digit.sv
// tb_seg_scan_4digit: scoreboard bench; a cycle-count reference model predicts outputs per edge.
module tb_seg_scan_4digit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic blank_lz = 1'b0;
  logic in_ready, frame_done;
  logic [3:0] an;
  logic [6:0] seg;
  seg_scan_4digit #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .blank_lz(blank_lz), .an(an), .seg(seg), .frame_done(frame_done)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic fd;
    logic rdy;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int n = 0;
  logic [15:0] m_disp = '0, m_pend = '0;
  bit m_full = 0, m_hs = 0;
  task automatic chk(string nm, logic [15:0] act, logic [15:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask
  // reference: 4 cycles per digit, 16 per frame, counted in edges since reset release
  initial forever begin
    int d;
    bit fb;
    logic [15:0] up;
    exp_t e;
    @(posedge clk);
    if (!reset) begin
      n = 0; m_disp = '0; m_pend = '0; m_full = 0; m_hs = 0;
    end else begin
      n++;
      fb = m_full;
      d = ((n - 1) / 4) % 4;
      up = m_disp >> (4 * d);
      e.an = ~(4'b0001 << d);
      e.seg = (blank_lz && d > 0 && up == 0) ? 7'h7F : font[up[3:0]];
      m_hs = in_valid && !fb;
      if (n % 16 == 0 && fb) begin m_disp = m_pend; m_full = 0; end
      if (m_hs) begin m_pend = in_data; m_full = 1; end
      e.fd = (n % 16 == 0);
      e.rdy = !m_full;
      q.push_back(e);
    end
  end
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (reset && q.size() > 0) begin
      e = q.pop_front();
      chk("an", 16'(an), 16'(e.an));
      chk("seg", 16'(seg), 16'(e.seg));
      chk("frame_done", 16'(frame_done), 16'(e.fd));
      chk("in_ready", 16'(in_ready), 16'(e.rdy));
    end
  end
  task automatic check_reset();
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_seg", 16'(seg), 16'h7F);
    chk("rst_frame_done", 16'(frame_done), 16'h0);
    chk("rst_in_ready", 16'(in_ready), 16'h1);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(int c);
    in_valid = 1'b0;
    repeat (c) step();
  endtask
  task automatic send(logic [15:0] w);
    int t = 0;
    in_valid = 1'b1;
    in_data = w;
    do begin step(); t++; end while (!m_hs && t < 64);
    chk("accept_timeout", 16'(m_hs), 16'h1);
    in_valid = 1'b0;
  endtask
  initial begin
    int t;
    #3 reset = 1'b0;
    repeat (3) step();
    check_reset();
    reset = 1'b1;
    step();
    chk("first_an", 16'(an), 16'hE);
    chk("first_seg", 16'(seg), 16'h40);
    idle(40);
    repeat (6) step();
    send(16'h1234);
    idle(40);
    send(16'hAAAA);
    send(16'h5555);
    idle(40);
    blank_lz = 1'b1;
    send(16'h0070);
    idle(40);
    send(16'h0000);
    idle(40);
    blank_lz = 1'b0;
    t = 0;
    while (!(n % 16 == 15 && !m_full) && t < 64) begin step(); t++; end
    in_valid = 1'b1;
    in_data = 16'hBEEF;
    step();
    chk("boundary_hs", 16'(m_hs), 16'h1);
    idle(40);
    send(16'hC0DE);
    step();
    #1 reset = 1'b0;
    q.delete();
    #1 check_reset();
    repeat (3) step();
    check_reset();
    reset = 1'b1;
    idle(40);
    repeat (300) begin
      in_valid = ($urandom % 6) == 0;
      in_data = 16'($urandom);
      if ($urandom % 16 == 0) blank_lz = ~blank_lz;
      step();
    end
    idle(4);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
